// File: rtl/snake_move_controller_pkg.sv
// Shared encodings and grid constants for the snake body datapath.
// Imported by the interface, the tick generator and the controller top.
package snake_pkg;

  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

endpackage

// File: rtl/snake_move_controller_if.sv
// Bundle between the snake controller, the navigation FSM and the VGA/score logic.
// master drives the controls and pixel queries; slave is the controller.
interface snake_move_controller_if #(
  parameter int MAX_LEN = 16
);
  import snake_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic             START;
  logic [1:0]       DIR;
  logic [X_W-1:0]   TARGET_X;
  logic [Y_W-1:0]   TARGET_Y;
  logic [X_W-1:0]   PIX_X;
  logic [Y_W-1:0]   PIX_Y;
  logic [X_W-1:0]   HEAD_X;
  logic [Y_W-1:0]   HEAD_Y;
  logic [LEN_W-1:0] LENGTH;
  logic [1:0]       STATE;
  logic             TARGET_REACHED;
  logic             FAILED;
  logic             SNAKE_HIT;
  logic             HEAD_HIT;

  modport master (
    output START, DIR, TARGET_X, TARGET_Y,
    output PIX_X, PIX_Y,
    input  HEAD_X, HEAD_Y, LENGTH, STATE,
    input  TARGET_REACHED, FAILED,
    input  SNAKE_HIT, HEAD_HIT
  );

  modport slave (
    input  START, DIR, TARGET_X, TARGET_Y,
    input  PIX_X, PIX_Y,
    output HEAD_X, HEAD_Y, LENGTH, STATE,
    output TARGET_REACHED, FAILED,
    output SNAKE_HIT, HEAD_HIT
  );

endinterface

// File: rtl/snake_move_controller_move_tick_gen.sv
// Free-running move tick counter: counts 0..TICK_CYCLES-1 while enabled,
// TICK is high during the terminal count cycle only.
module move_tick_gen #(
  parameter int TICK_CYCLES = 10000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/snake_move_controller.sv
// Snake body datapath: per move tick, forms the wrapped head candidate,
// checks self-collision and target, shifts segments, answers pixel queries.
module snake_move_controller #(
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  parameter int MAX_LEN     = 16,
  parameter int INIT_LEN    = 4,
  parameter int TICK_CYCLES = 10000000,
  parameter int START_X     = 20,
  parameter int START_Y     = 60
) (
  input logic CLK,
  input logic RESET,
  snake_move_controller_if.slave bus
);
  import snake_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [X_W-1:0] XMAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(GRID_H - 1);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);

  state_e           state;
  logic [X_W-1:0]   seg_x [MAX_LEN];
  logic [Y_W-1:0]   seg_y [MAX_LEN];
  logic [LEN_W-1:0] len;
  logic             tgt_pulse;
  logic             failed;
  logic             snake_hit;
  logic             head_hit;

  logic           tick;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           hit_self;
  logic           hit_tgt;
  logic           q_snake;

  move_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (state == ST_RUN),
    .CLR   (state != ST_RUN),
    .TICK  (tick)
  );

  always_comb begin
    cand_x = seg_x[0];
    cand_y = seg_y[0];
    unique case (1'b1)
      bus.DIR == DIR_UP:
        cand_y = (seg_y[0] == '0) ? YMAX : seg_y[0] - 1'b1;
      bus.DIR == DIR_RIGHT:
        cand_x = (seg_x[0] == XMAX) ? '0 : seg_x[0] + 1'b1;
      bus.DIR == DIR_DOWN:
        cand_y = (seg_y[0] == YMAX) ? '0 : seg_y[0] + 1'b1;
      bus.DIR == DIR_LEFT:
        cand_x = (seg_x[0] == '0) ? XMAX : seg_x[0] - 1'b1;
      default: ;
    endcase
  end

  // The tail vacates on this move, so only seg[0..len-2] can be hit.
  always_comb begin
    hit_self = 1'b0;
    for (int i = 0; i < MAX_LEN - 1; i++) begin
      if ((LEN_W'(i) < len - 1'b1) &&
          seg_x[i] == cand_x && seg_y[i] == cand_y)
        hit_self = 1'b1;
    end
    hit_tgt = (cand_x == bus.TARGET_X) &&
              (cand_y == bus.TARGET_Y);
  end

  always_comb begin
    q_snake = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len) &&
          seg_x[i] == bus.PIX_X && seg_y[i] == bus.PIX_Y)
        q_snake = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      len       <= LEN_W'(INIT_LEN);
      tgt_pulse <= 1'b0;
      failed    <= 1'b0;
      snake_hit <= 1'b0;
      head_hit  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_W'(START_X - i);
        seg_y[i] <= Y_W'(START_Y);
      end
    end else begin
      snake_hit <= q_snake;
      head_hit  <= (bus.PIX_X == seg_x[0]) &&
                   (bus.PIX_Y == seg_y[0]);
      tgt_pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.START) state <= ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            if (hit_self) begin
              state  <= ST_DEAD;
              failed <= 1'b1;
            end else begin
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0] <= cand_x;
              seg_y[0] <= cand_y;
              if (hit_tgt) begin
                tgt_pulse <= 1'b1;
                if (len != LMAX) len <= len + 1'b1;
              end
            end
          end
        end
        ST_DEAD: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.HEAD_X         = seg_x[0];
  assign bus.HEAD_Y         = seg_y[0];
  assign bus.LENGTH         = len;
  assign bus.STATE          = state;
  assign bus.TARGET_REACHED = tgt_pulse;
  assign bus.FAILED         = failed;
  assign bus.SNAKE_HIT      = snake_hit;
  assign bus.HEAD_HIT       = head_hit;

endmodule

// File: tb/tb_snake_move_controller.sv
// Directed bench for snake_move_controller with a queue scoreboard:
// expectations are pushed when stimulus is driven and popped at the sample point.
module tb_snake_move_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  snake_move_controller_if #(.MAX_LEN(16)) sif();

  snake_move_controller #(
    .GRID_W      (160),
    .GRID_H      (120),
    .MAX_LEN     (16),
    .INIT_LEN    (4),
    .TICK_CYCLES (4),
    .START_X     (20),
    .START_Y     (60)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (sif.slave)
  );

  int    checks = 0;
  int    errors = 0;
  string tq[$];
  int    eq[$];

  task automatic want(input string t, input int v);
    tq.push_back(t);
    eq.push_back(v);
  endtask

  task automatic got(input logic [31:0] o);
    string t;
    int    e;
    checks++;
    if (eq.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %0d expected none", o);
      return;
    end
    t = tq.pop_front();
    e = eq.pop_front();
    assert (o === 32'(e)) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", t, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sif.START = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Leaves the DUT in its first RUN cycle with the tick counter at 0.
  task automatic go;
    sif.START = 1'b1;
    step(1);
    sif.START = 1'b0;
  endtask

  initial begin
    sif.START    = 1'b0;
    sif.DIR      = 2'b01;
    sif.TARGET_X = 8'd100;
    sif.TARGET_Y = 7'd100;
    sif.PIX_X    = 8'd0;
    sif.PIX_Y    = 7'd0;

    // reset state and idle hold
    do_reset;
    want("rst_hx", 20);  got(sif.HEAD_X);
    want("rst_hy", 60);  got(sif.HEAD_Y);
    want("rst_len", 4);  got(sif.LENGTH);
    want("rst_state", 0); got(sif.STATE);
    want("rst_tr", 0);   got(sif.TARGET_REACHED);
    want("rst_failed", 0); got(sif.FAILED);
    want("rst_shit", 0); got(sif.SNAKE_HIT);
    want("idle_hx", 20);
    want("idle_state", 0);
    want("idle_tr", 0);
    step(20);
    got(sif.HEAD_X);
    got(sif.STATE);
    got(sif.TARGET_REACHED);
    sif.PIX_X = 8'd17; sif.PIX_Y = 7'd60;
    want("idle_q_tail", 1); step(1); got(sif.SNAKE_HIT);
    sif.PIX_X = 8'd16;
    want("idle_q_beyond", 0); step(1); got(sif.SNAKE_HIT);
    sif.PIX_X = 8'd20;
    want("idle_q_head", 1); step(1); got(sif.HEAD_HIT);

    // moving right with queries
    do_reset;
    sif.DIR = 2'b01;
    go;
    want("run_state", 1); got(sif.STATE);
    want("r_t1_hx", 21); step(4); got(sif.HEAD_X);
    want("r_t3_hx", 23); step(8); got(sif.HEAD_X);
    sif.PIX_X = 8'd20; sif.PIX_Y = 7'd60;
    want("r_q_seg3", 1); step(1); got(sif.SNAKE_HIT);
    sif.PIX_X = 8'd21;
    want("r_q_21", 1); step(1); got(sif.SNAKE_HIT);
    sif.PIX_X = 8'd24;
    want("r_q_24", 0);
    want("r_q_24_head", 0);
    step(1);
    got(sif.SNAKE_HIT);
    got(sif.HEAD_HIT);

    // target hit
    do_reset;
    sif.TARGET_X = 8'd22; sif.TARGET_Y = 7'd60;
    sif.DIR = 2'b01;
    go;
    want("t_t1_tr", 0);
    want("t_t1_hx", 21);
    step(4);
    got(sif.TARGET_REACHED);
    got(sif.HEAD_X);
    want("t_t2_tr", 1);
    want("t_t2_len", 5);
    want("t_t2_hx", 22);
    step(4);
    got(sif.TARGET_REACHED);
    got(sif.LENGTH);
    got(sif.HEAD_X);
    sif.PIX_X = 8'd18; sif.PIX_Y = 7'd60;
    want("t_tr_once", 0);
    want("t_tail_18", 1);
    step(1);
    got(sif.TARGET_REACHED);
    got(sif.SNAKE_HIT);

    // vertical wrap moving up
    do_reset;
    sif.TARGET_X = 8'd100; sif.TARGET_Y = 7'd100;
    sif.DIR = 2'b00;
    go;
    want("u_t60_hy", 0);
    want("u_t60_hx", 20);
    step(240);
    got(sif.HEAD_Y);
    got(sif.HEAD_X);
    want("u_t61_hy", 119);
    want("u_t61_failed", 0);
    want("u_t61_state", 1);
    step(4);
    got(sif.HEAD_Y);
    got(sif.FAILED);
    got(sif.STATE);

    // horizontal wrap moving right
    do_reset;
    sif.DIR = 2'b01;
    go;
    want("x_t139_hx", 159); step(4 * 139); got(sif.HEAD_X);
    want("x_t140_hx", 0);   step(4);       got(sif.HEAD_X);

    // reversal collides; collision beats target
    do_reset;
    sif.TARGET_X = 8'd19; sif.TARGET_Y = 7'd60;
    sif.DIR = 2'b11;
    go;
    want("c_failed", 1);
    want("c_state", 2);
    want("c_hx", 20);
    want("c_hy", 60);
    want("c_len", 4);
    want("c_tr", 0);
    step(4);
    got(sif.FAILED);
    got(sif.STATE);
    got(sif.HEAD_X);
    got(sif.HEAD_Y);
    got(sif.LENGTH);
    got(sif.TARGET_REACHED);
    sif.START = 1'b1;
    sif.DIR = 2'b01;
    sif.TARGET_X = 8'd21;
    want("d_state", 2);
    want("d_hx", 20);
    want("d_failed", 1);
    want("d_tr", 0);
    step(12);
    got(sif.STATE);
    got(sif.HEAD_X);
    got(sif.FAILED);
    got(sif.TARGET_REACHED);
    sif.START = 1'b0;

    // reset mid-run restarts everything including the tick counter
    do_reset;
    sif.TARGET_X = 8'd100; sif.TARGET_Y = 7'd100;
    sif.DIR = 2'b01;
    go;
    want("m_t5_hx", 25); step(20); got(sif.HEAD_X);
    rst = 1'b1;
    want("m_rst_hx", 20);
    want("m_rst_len", 4);
    want("m_rst_state", 0);
    step(1);
    got(sif.HEAD_X);
    got(sif.LENGTH);
    got(sif.STATE);
    rst = 1'b0;
    go;
    want("m_pre_tick_hx", 20); step(3); got(sif.HEAD_X);
    want("m_tick_hx", 21);     step(1); got(sif.HEAD_X);

    if (eq.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed %0d expected 0", eq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_move_controller.md
Name: snake_move_controller

Overview:
- Sequences the snake body datapath: once per move tick it samples DIR from the navigation FSM, computes the new head position with wrap-around, shifts the body segment registers and detects target hits and self-collision.
- Sits between the navigation FSM (DIR source) and the VGA/score logic. The VGA/score logic queries pixel occupancy through this block and consumes TARGET_REACHED and FAILED.

Parameters:
- GRID_W, 160, grid width in cells; X coordinate is 8 bits.
- GRID_H, 120, grid height in cells; Y coordinate is 7 bits.
- MAX_LEN, 16, number of segment registers; maximum snake length.
- INIT_LEN, 4, length after reset; must satisfy 3 <= INIT_LEN <= MAX_LEN.
- TICK_CYCLES, 10000000, CLK cycles per move tick; the bench uses 4.
- START_X, 20, head X after reset.
- START_Y, 60, head Y after reset.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  level or pulse; moves the controller from IDLE to RUN.
- DIR  in  2  direction: 00 up (Y-1), 01 right (X+1), 10 down (Y+1), 11 left (X-1).
- TARGET_X  in  8  current target X.
- TARGET_Y  in  7  current target Y.
- PIX_X  in  8  query X from the VGA logic.
- PIX_Y  in  7  query Y from the VGA logic.
- HEAD_X  out  8  segment 0 X.
- HEAD_Y  out  7  segment 0 Y.
- LENGTH  out  clog2(MAX_LEN+1)  current length.
- STATE  out  2  00 IDLE, 01 RUN, 10 DEAD.
- TARGET_REACHED  out  1  one-cycle pulse when the head lands on the target.
- FAILED  out  1  high while in DEAD.
- SNAKE_HIT  out  1  registered: (PIX_X,PIX_Y) matches any active segment.
- HEAD_HIT  out  1  registered: (PIX_X,PIX_Y) matches the head.

Behaviour:
- Reset values:
  - State IDLE; LENGTH = INIT_LEN.
  - seg[i] = (START_X - i, START_Y) for every i < MAX_LEN.
  - Tick counter = 0; TARGET_REACHED, FAILED, SNAKE_HIT, HEAD_HIT all 0.
  - Reset asserted mid-operation restores all of the above on the next edge.
- IDLE:
  - Tick counter held at 0; no moves.
  - START = 1 -> RUN on the next edge.
- RUN:
  - Tick counter counts 0 .. TICK_CYCLES-1 and wraps.
  - The terminal count cycle is the move cycle; the first move happens TICK_CYCLES cycles after entering RUN.
- Move cycle:
  - Sample DIR in that cycle and form the candidate head from seg[0].
  - Wrap rules: X=GRID_W-1 moving right -> 0; X=0 moving left -> GRID_W-1; Y=0 moving up -> GRID_H-1; Y=GRID_H-1 moving down -> 0.
- Collision:
  - Compare the candidate against seg[0 .. LENGTH-2].
  - The tail seg[LENGTH-1] vacates, so it is excluded.
  - On a match -> DEAD on the next edge; segments and LENGTH are not updated.
- Legal move:
  - seg[i] <= seg[i-1] for i = 1 .. MAX_LEN-1, and seg[0] <= candidate.
  - Registers beyond LENGTH shift too but are ignored.
- Target hit:
  - Condition: candidate equals (TARGET_X, TARGET_Y) and the move is legal.
  - TARGET_REACHED is high for exactly the one cycle after the move edge.
  - LENGTH increments, saturating at MAX_LEN; the pulse still fires when saturated.
  - The new tail is the old tail position, carried by the shift.
- Collision and target on the same tick: collision wins, no pulse.
- A DIR reversal is not filtered; it collides with seg[1] -> DEAD.
- DEAD:
  - FAILED = 1; all positions and LENGTH frozen.
  - START ignored; only RESET exits.
  - START is also ignored in RUN.
- Query path:
  - SNAKE_HIT and HEAD_HIT have 1-cycle latency from PIX_X/PIX_Y.
  - Valid in every state; only segments i < LENGTH count.

Decomposition:
- Package snake_pkg:
  - DIR encodings: DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT.
  - State encodings: ST_IDLE, ST_RUN, ST_DEAD.
  - Grid constants: GRID_W, GRID_H, X_W = 8, Y_W = 7.
- One sub-module, move_tick_gen:
  - Parameterised TICK_CYCLES counter with enable and synchronous clear.
  - Outputs a single-cycle TICK.

Test Plan:
- RESET, then 20 cycles with START = 0 -> HEAD = (20,60), LENGTH = 4, STATE = 00, no change, TARGET_REACHED = 0.
- START pulse, DIR = 01, TICK_CYCLES = 4:
  - HEAD_X = 21 at tick 1 and 23 at tick 3; seg[3] = (20,60).
  - Query PIX = (21,60) -> SNAKE_HIT = 1 one cycle later; PIX = (24,60) -> 0.
- Target (22,60), DIR = 01 -> TARGET_REACHED pulses exactly once after tick 2; LENGTH = 5; the tail stays at (18,60) that tick.
- DIR = 00 from (20,60) for 61 ticks -> HEAD_Y goes 0 at tick 60 then 119 at tick 61, no FAILED.
- START, DIR = 11 -> tick 1 collides with seg[1] = (19,60): FAILED = 1, STATE = 10, HEAD stays (20,60). Further ticks and START produce no change.
- RESET asserted during RUN at tick 5 -> next cycle HEAD = (20,60), LENGTH = 4, STATE = 00, counter restarted.
